// File: rtl/fft_filter_seq_if.sv
// ----------------------------------------------------------------------------
// fft_filter_seq_if
// Bundle of the bin stream entering the frequency-domain filter sequencer and
// the coefficient-ROM / tag signals it produces.
//
// Handshake: a bin beat is accepted on every rising clock edge where in_valid
// is high. There is no backpressure, so in_sop and bank_sel are only looked
// at on accepted beats. bank_sel is used only on sop beats. Every output is
// registered and is valid for the whole cycle after the edge that produced it.
//
// Signals (directions as seen by the slave, i.e. the sequencer):
//   in_valid     in   FFT bin valid this cycle
//   in_sop       in   first bin of a frame (qualified by in_valid)
//   bank_sel     in   coefficient bank, sampled on sop beats
//   coef_addr    out  ROM address {bank, bin}
//   coef_en      out  ROM / operand register enable, one cycle per beat
//   out_valid    out  multiplier output valid
//   out_sop      out  multiplier output is bin 0
//   out_eop      out  multiplier output is bin N_BINS-1
//   frame_err    out  one-cycle framing error pulse
//   frame_count  out  completed frames, wraps
//   busy         out  frame open or tags still in flight
//   dbg_state    out  FSM state (0 = IDLE, 1 = RUN)
// ----------------------------------------------------------------------------
interface fft_filter_seq_if #(
  parameter int ADDR_W = 5,
  parameter int BANK_W = 2,
  parameter int CNT_W  = 16
);
  logic                     in_valid;
  logic                     in_sop;
  logic [BANK_W-1:0]        bank_sel;
  logic [BANK_W+ADDR_W-1:0] coef_addr;
  logic                     coef_en;
  logic                     out_valid;
  logic                     out_sop;
  logic                     out_eop;
  logic                     frame_err;
  logic [CNT_W-1:0]         frame_count;
  logic                     busy;
  logic                     dbg_state;

  modport slave (
    input  in_valid, in_sop, bank_sel,
    output coef_addr, coef_en, out_valid, out_sop, out_eop,
           frame_err, frame_count, busy, dbg_state
  );

  modport master (
    output in_valid, in_sop, bank_sel,
    input  coef_addr, coef_en, out_valid, out_sop, out_eop,
           frame_err, frame_count, busy, dbg_state
  );
endinterface

// File: rtl/fft_filter_seq.sv
// ----------------------------------------------------------------------------
// fft_filter_seq
// Frame sequencer for the frequency-domain filter that follows the FFT.
// It turns the incoming bin strobe stream into coefficient ROM addresses
// {bank, bin}, restarting at bin 0 on each start-of-frame, and carries
// valid/sop/eop tags through a delay line matched to the ROM + multiplier
// latency so the product stream leaves framed and aligned.
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   fbus   fft_filter_seq_if.slave, see the interface header for signals
// ----------------------------------------------------------------------------
module fft_filter_seq #(
  parameter int N_BINS   = 32,
  parameter int ADDR_W   = 5,
  parameter int BANK_W   = 2,
  parameter int PIPE_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  fft_filter_seq_if.slave fbus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);

  // Tag bit positions inside one delay-line stage.
  localparam int TAG_V = 2;
  localparam int TAG_S = 1;
  localparam int TAG_E = 0;

  logic [0:0]               state_q, state_d;
  logic [ADDR_W-1:0]        bin_cnt_q, bin_cnt_d;
  logic [BANK_W-1:0]        bank_q, bank_d;
  logic [BANK_W+ADDR_W-1:0] coef_addr_q;
  logic                     coef_en_q;
  logic                     frame_err_q, frame_err_d;
  logic [CNT_W-1:0]         frame_count_q;

  // Stage 0 is loaded at the accepting edge; stage PIPE_LAT is therefore
  // visible exactly PIPE_LAT edges later and drives the outputs.
  logic [2:0]               tag_q [0:PIPE_LAT];
  logic [2:0]               tag_d;

  logic                     emit;
  logic [ADDR_W-1:0]        emit_bin;
  logic [BANK_W-1:0]        emit_bank;
  logic                     tag_sop, tag_eop;
  logic                     tags_in_flight;

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    bank_d      = bank_q;
    frame_err_d = 1'b0;
    emit        = 1'b0;
    emit_bin    = '0;
    emit_bank   = bank_q;
    tag_sop     = 1'b0;
    tag_eop     = 1'b0;
    if (fbus.in_valid) begin
      if (fbus.in_sop) begin
        // A sop while RUN means the previous frame was truncated; RUN always
        // has bin_cnt != 0, so this is a genuine mid-frame restart.
        frame_err_d = (state_q == ST_RUN);
        bank_d      = fbus.bank_sel;
        emit        = 1'b1;
        emit_bin    = '0;
        emit_bank   = fbus.bank_sel;
        tag_sop     = 1'b1;
        bin_cnt_d   = ADDR_W'(1);
        state_d     = ST_RUN;
      end else if (state_q == ST_IDLE) begin
        // Beat outside any frame: dropped, only flagged.
        frame_err_d = 1'b1;
      end else begin
        emit     = 1'b1;
        emit_bin = bin_cnt_q;
        if (bin_cnt_q == LAST_BIN) begin
          tag_eop   = 1'b1;
          bin_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          bin_cnt_d = bin_cnt_q + ADDR_W'(1);
        end
      end
    end
    tag_d = {emit, tag_sop, tag_eop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bin_cnt_q     <= '0;
      bank_q        <= '0;
      coef_addr_q   <= '0;
      coef_en_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      for (int i = 0; i <= PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      bank_q      <= bank_d;
      coef_en_q   <= emit;
      frame_err_q <= frame_err_d;
      // Address holds between beats so the ROM input stays quiet.
      if (emit) coef_addr_q <= {emit_bank, emit_bin};
      if (tag_q[PIPE_LAT][TAG_E]) frame_count_q <= frame_count_q + CNT_W'(1);
      tag_q[0] <= tag_d;
      for (int i = 1; i <= PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    tags_in_flight = 1'b0;
    for (int i = 0; i <= PIPE_LAT; i++) tags_in_flight = tags_in_flight | tag_q[i][TAG_V];
  end

  assign fbus.coef_addr   = coef_addr_q;
  assign fbus.coef_en     = coef_en_q;
  assign fbus.out_valid   = tag_q[PIPE_LAT][TAG_V];
  assign fbus.out_sop     = tag_q[PIPE_LAT][TAG_S];
  assign fbus.out_eop     = tag_q[PIPE_LAT][TAG_E];
  assign fbus.frame_err   = frame_err_q;
  assign fbus.frame_count = frame_count_q;
  assign fbus.busy        = (state_q != ST_IDLE) | tags_in_flight;
  assign fbus.dbg_state   = state_q;

endmodule

// File: tb/tb_fft_filter_seq.sv
module tb_fft_filter_seq;
  localparam int N_BINS   = 32;
  localparam int ADDR_W   = 5;
  localparam int BANK_W   = 2;
  localparam int PIPE_LAT = 4;
  localparam int CNT_W    = 16;
  localparam int AW       = BANK_W + ADDR_W;
  localparam int MAXC     = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_filter_seq_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .CNT_W(CNT_W)) bus_if ();

  fft_filter_seq #(
    .N_BINS(N_BINS), .ADDR_W(ADDR_W), .BANK_W(BANK_W),
    .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fbus (bus_if)
  );

  // ---------------- scoreboard ----------------
  // Timeline model: slot k holds what the outputs must show between edge k-1
  // and edge k (edge 0 is the first edge after reset release).
  logic [AW-1:0] exp_q[$];
  bit exp_en [MAXC];
  bit exp_ov [MAXC];
  bit exp_os [MAXC];
  bit exp_oe [MAXC];
  bit exp_err[MAXC];
  bit exp_st [MAXC];
  bit exp_fl [MAXC];

  int            cur;
  logic [AW-1:0] last_addr;
  logic [CNT_W-1:0] cnt_seen;
  int            n_checks;
  int            n_pass;

  // Frame-level reference state.
  bit m_in_frame;
  int m_pos;
  int m_bank;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s slot=%0d got=%0h expected=%0h", tag, cur, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      exp_en[i] = 0; exp_ov[i] = 0; exp_os[i] = 0; exp_oe[i] = 0;
      exp_err[i] = 0; exp_st[i] = 0; exp_fl[i] = 0;
    end
    exp_q.delete();
    last_addr  = '0;
    cnt_seen   = '0;
    m_in_frame = 0;
    m_pos      = 0;
    m_bank     = 0;
    cur        = 0;
  endtask

  task automatic check_slot();
    if (exp_en[cur] && exp_q.size() > 0) last_addr = exp_q.pop_front();
    check_eq("coef_en",     32'(bus_if.coef_en),     32'(exp_en[cur]));
    check_eq("coef_addr",   32'(bus_if.coef_addr),   32'(last_addr));
    check_eq("out_valid",   32'(bus_if.out_valid),   32'(exp_ov[cur]));
    check_eq("out_sop",     32'(bus_if.out_sop),     32'(exp_os[cur]));
    check_eq("out_eop",     32'(bus_if.out_eop),     32'(exp_oe[cur]));
    check_eq("frame_err",   32'(bus_if.frame_err),   32'(exp_err[cur]));
    check_eq("frame_count", 32'(bus_if.frame_count), 32'(cnt_seen));
    check_eq("busy",        32'(bus_if.busy),        32'(exp_st[cur] | exp_fl[cur]));
    if (exp_oe[cur]) cnt_seen = cnt_seen + 1'b1;
  endtask

  // Reference: what the accepting edge `cur` does to the frame.
  task automatic model_beat(input bit v, input bit sop, input int bank);
    bit emit, err, tsop, teop;
    int bin;
    emit = 0; err = 0; tsop = 0; teop = 0; bin = 0;
    if (v) begin
      if (sop) begin
        err = m_in_frame;
        m_bank = bank; bin = 0; emit = 1; tsop = 1;
        m_pos = 1; m_in_frame = 1;
      end else if (!m_in_frame) begin
        err = 1;
      end else begin
        bin = m_pos; emit = 1;
        if (bin == N_BINS - 1) begin
          teop = 1; m_in_frame = 0; m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
    exp_err[cur+1] = err;
    exp_st[cur+1]  = m_in_frame;
    if (emit) begin
      exp_en[cur+1] = 1;
      exp_q.push_back(AW'(m_bank * N_BINS + bin));
      exp_ov[cur+PIPE_LAT+1] = 1;
      exp_os[cur+PIPE_LAT+1] = tsop;
      exp_oe[cur+PIPE_LAT+1] = teop;
      for (int k = 1; k <= PIPE_LAT + 1; k++) exp_fl[cur+k] = 1;
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: check the current slot, drive the beat for the next
  // edge, then advance one cycle.
  task automatic step(input bit v, input bit sop, input int bank);
    check_slot();
    bus_if.in_valid = v;
    bus_if.in_sop   = sop;
    bus_if.bank_sel = BANK_W'(bank);
    model_beat(v, sop, bank);
    @(negedge clk);
    cur++;
  endtask

  task automatic idle_step();
    step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
  endtask

  task automatic send_frame(input int bank, input bit gappy);
    for (int b = 0; b < N_BINS; b++) begin
      step(1, b == 0, (b == 0) ? bank : int'($urandom_range(0, 3)));
      if (gappy) idle_step();
    end
  endtask

  task automatic do_reset(input bit mid_cycle);
    if (mid_cycle) begin
      #2 reset = 1'b1;
      #1;
      check_eq("rst_coef_en",   32'(bus_if.coef_en),     32'd0);
      check_eq("rst_coef_addr", 32'(bus_if.coef_addr),   32'd0);
      check_eq("rst_out_valid", 32'(bus_if.out_valid),   32'd0);
      check_eq("rst_out_sop",   32'(bus_if.out_sop),     32'd0);
      check_eq("rst_out_eop",   32'(bus_if.out_eop),     32'd0);
      check_eq("rst_frame_err", 32'(bus_if.frame_err),   32'd0);
      check_eq("rst_frame_cnt", 32'(bus_if.frame_count), 32'd0);
      check_eq("rst_busy",      32'(bus_if.busy),        32'd0);
    end else begin
      reset = 1'b1;
    end
    bus_if.in_valid = 1'b0;
    bus_if.in_sop   = 1'b0;
    bus_if.bank_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_model();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle_step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.in_sop   = 1'b0;
    bus_if.bank_sel = '0;
    clear_model();
    do_reset(0);

    // Contiguous frame, bank 1.
    send_frame(1, 0);
    drain(8);

    // Alternate-cycle frame, bank 0.
    do_reset(0);
    send_frame(0, 1);
    drain(8);

    // Back-to-back frames bank 0 then bank 3.
    do_reset(0);
    send_frame(0, 0);
    send_frame(3, 0);
    drain(8);

    // Restart at bin 10, then the second frame completes.
    do_reset(0);
    for (int b = 0; b < 10; b++) step(1, b == 0, (b == 0) ? 2 : 0);
    send_frame(1, 0);
    drain(8);

    // Non-sop beats while idle.
    do_reset(0);
    for (int i = 0; i < 3; i++) step(1, 0, int'($urandom_range(0, 3)));
    drain(8);

    // Async reset once bins 0..16 were accepted, then a fresh frame.
    do_reset(0);
    for (int b = 0; b < 17; b++) step(1, b == 0, (b == 0) ? 3 : 1);
    do_reset(1);
    drain(3);
    send_frame(int'($urandom_range(0, 3)), 0);
    drain(8);

    // Random traffic: gaps, stray beats, occasional restarts.
    do_reset(0);
    for (int i = 0; i < 600; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = (!m_in_frame && $urandom_range(0, 3) != 0) || ($urandom_range(0, 63) == 0);
      if (v) step(1, s, int'($urandom_range(0, 3)));
      else idle_step();
    end
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fft_filter_seq.md
Name: fft_filter_seq

Overview:
- Frame sequencer for the frequency-domain filter datapath (coefficient ROM pair + complex multiplier) that sits after the FFT.
- Accepts a per-bin valid/start-of-frame strobe stream and generates the per-bin coefficient ROM address, restarting at bin 0 on every frame.
- Selects one of several coefficient banks per frame.
- Carries valid/sop/eop tags through a delay line matched to datapath latency, so downstream sees framed, aligned output.

Parameters:
- N_BINS, 32, bins per frame (power of two).
- ADDR_W, 5, bin index width (log2 N_BINS).
- BANK_W, 2, coefficient bank select width.
- PIPE_LAT, 4, cycles from the accepting edge of an input beat to its product at the multiplier output (ROM 1 + operand delay + multiplier); minimum 2.
- CNT_W, 16, completed-frame counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  FFT bin valid this cycle.
- in_sop  in  1  first bin of a frame; qualified by in_valid.
- bank_sel  in  BANK_W  coefficient bank; sampled only on a sop beat.
- coef_addr  out  BANK_W+ADDR_W  ROM address {bank, bin}.
- coef_en  out  1  ROM/operand-register enable; high for one cycle per accepted beat.
- out_valid  out  1  multiplier output valid.
- out_sop  out  1  output bin 0 of a complete-able frame.
- out_eop  out  1  output bin N_BINS-1.
- frame_err  out  1  one-cycle framing-error pulse.
- frame_count  out  CNT_W  number of completed frames; wraps.
- busy  out  1  high when state is not IDLE or any tag is in the delay line.

Behaviour:
- Reset (async, immediate): state IDLE; bin_cnt=0; bank_q=0; tag delay line cleared; every output 0.
- FSM has two states, IDLE and RUN. Accepted beat = in_valid high at a rising edge.
- IDLE:
  - in_valid & in_sop: bank_q<=bank_sel; emit bin 0; bin_cnt<=1; go to RUN.
  - in_valid & !in_sop: beat dropped (no coef_en, no tag); frame_err pulses.
- RUN:
  - Each accepted beat with !in_sop: emit bin bin_cnt; bin_cnt++.
  - When the emitted bin is N_BINS-1: tag eop; bin_cnt<=0; go to IDLE.
  - The next frame may start on the very next cycle; no bubble is required.
  - in_valid low: hold all state; emit nothing. Gaps of any length are allowed.
  - in_valid & in_sop (mid-frame, bin_cnt!=0): frame_err pulses; bank_q<=bank_sel; emit bin 0 with sop tag; bin_cnt<=1; stay in RUN. Beats of the truncated frame still exit the delay line with out_valid, but never with out_eop.
- Emit bin b (registered at the accepting edge):
  - coef_en=1 for exactly the following cycle.
  - coef_addr={bank, b}, where bank is bank_sel when the beat is a sop beat and bank_q otherwise.
  - coef_addr holds its last value while coef_en=0.
  - bank_sel changes mid-frame have no effect.
- Tag delay line:
  - {valid, sop, eop} entered at the accepting edge.
  - out_valid/out_sop/out_eop rise exactly PIPE_LAT rising edges after the accepting edge.
  - Gap pattern is preserved one-for-one.
- frame_count increments on the cycle out_eop is high.
- frame_err is registered; two errors on consecutive cycles give two consecutive pulses.
- A sop beat at bin_cnt==0 in RUN cannot occur, because bin_cnt==0 implies IDLE.
- Reset asserted mid-frame discards the in-flight tags; the next sop starts at bin 0 of bank_sel.

Test Plan:
- After reset, bank_sel=1, 32 contiguous beats with sop on the first -> coef_addr 32..63 on consecutive cycles starting one cycle after the first beat; out_valid high for 32 cycles starting 4 cycles after the first accepting edge; out_sop on the first and out_eop on the last; frame_count=1; busy falls the cycle after out_eop.
- Same frame with in_valid on alternate cycles -> addresses 0..31 with coef_en alternating; out_valid shows the same alternating pattern delayed by 4; eop on the 32nd valid.
- Two back-to-back frames with bank 0 then bank 3 and no idle cycle -> addresses 0..31 then 96..127 with no bubble; two out_eop pulses 32 cycles apart; frame_count=2.
- New sop at bin 10 of a frame -> frame_err for one cycle; address restarts at {bank,0}; first 10 outputs carry no eop; frame_count counts only the completed second frame.
- in_valid without sop in IDLE for 3 beats -> no coef_en, no out_valid, three frame_err pulses.
- Async reset mid-cycle at bin 17 -> all outputs 0 before the next edge with no tag leakage afterwards; the following sop frame outputs addresses from bin 0.
